// File: rtl/mem_port_arbiter.sv
// Four-requester memory port arbiter: round-robin or fixed priority, grant held
// for a whole valid/ready transaction, optional stall watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no transaction; mem_valid=0, gnt=0, sel holds its last value
//   BUSY  | transaction to requester sel; mem_valid=1, gnt=onehot(sel)
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT    = 16,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       mem_ready,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       mem_valid,
   output logic [3:0] ack,
   output logic       err
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
   logic              timeout;
   logic [1:0]        pick_idx;

   // Scan from the highest offset down so the lowest offset (highest priority) wins.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      pick = ptr;
      for (int i = 3; i >= 0; i--) begin
         if (FIXED_PRIO) idx = 2'(i);
         else            idx = ptr + 2'(i);
         if (r[idx]) pick = idx;
      end
   endfunction

   assign timeout = (TIMEOUT > 0) && (state_q == BUSY) && !mem_ready &&
                    (wd_cnt_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
      wd_cnt_d = wd_cnt_q;
      err      = 1'b0;
      pick_idx = 2'd0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               pick_idx = pick(req, rr_ptr_q);
               state_d  = BUSY;
               sel_d    = pick_idx;
               gnt_d    = 4'b0001 << pick_idx;
               wd_cnt_d = '0;
            end
         end
         BUSY: begin
            if (mem_ready || timeout) begin
               // Completion and abort both release the port; re-arbitrate with the advanced pointer.
               err      = timeout;
               rr_ptr_d = sel_q + 2'd1;
               wd_cnt_d = '0;
               if (|req) begin
                  pick_idx = pick(req, sel_q + 2'd1);
                  sel_d    = pick_idx;
                  gnt_d    = 4'b0001 << pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
               end
            end else if (TIMEOUT > 0) begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= 2'd0;
         gnt_q    <= 4'b0000;
         rr_ptr_q <= 2'd0;
         wd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign mem_valid = (state_q == BUSY);
   assign ack       = gnt_q & {4{mem_ready & mem_valid}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a is round-robin with a 4-cycle watchdog, dut_b is fixed
// priority with the watchdog disabled.
module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_a, req_b;
   logic       rdy_a, rdy_b;
   logic [3:0] gnt_a, gnt_b, ack_a, ack_b;
   logic [1:0] sel_a, sel_b;
   logic       mv_a, mv_b, err_a, err_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .mem_ready(rdy_a),
      .gnt(gnt_a), .sel(sel_a), .mem_valid(mv_a), .ack(ack_a), .err(err_a));

   mem_port_arbiter #(.TIMEOUT(0), .FIXED_PRIO(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .mem_ready(rdy_b),
      .gnt(gnt_b), .sel(sel_b), .mem_valid(mv_b), .ack(ack_b), .err(err_b));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 4'b0000; rdy_a = 1'b0;
      req_b = 4'b0000; rdy_b = 1'b0;
      mid();
      chk("rst_gnt", gnt_a, 4'b0000);
      chk("rst_sel", {2'b00, sel_a}, 4'd0);
      chk("rst_mv",  {3'b000, mv_a}, 4'd0);
      chk("rst_ack", ack_a, 4'b0000);
      chk("rst_err", {3'b000, err_a}, 4'd0);

      // Round-robin, all requesting, memory always ready.
      tick();
      rst_n = 1'b1;
      req_a = 4'b1111; rdy_a = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 4) req_a = 4'b0000;
         mid();
         chk($sformatf("rr_sel%0d", k), {2'b00, sel_a}, 4'(k % 4));
         chk($sformatf("rr_gnt%0d", k), gnt_a, 4'b0001 << (k % 4));
         chk($sformatf("rr_ack%0d", k), ack_a, 4'b0001 << (k % 4));
         chk($sformatf("rr_mv%0d", k), {3'b000, mv_a}, 4'd1);
      end
      tick();
      rdy_a = 1'b0;
      mid();
      chk("rr_idle_mv",  {3'b000, mv_a}, 4'd0);
      chk("rr_idle_gnt", gnt_a, 4'b0000);

      // Single request from requester 2, ready on the third busy cycle.
      req_a = 4'b0100;
      tick(); mid();
      chk("t1_gnt", gnt_a, 4'b0100);
      chk("t1_sel", {2'b00, sel_a}, 4'd2);
      chk("t1_mv",  {3'b000, mv_a}, 4'd1);
      tick(); mid();
      chk("t1_wait_ack", ack_a, 4'b0000);
      tick();
      rdy_a = 1'b1; req_a = 4'b0000;
      mid();
      chk("t1_ack", ack_a, 4'b0100);
      chk("t1_err", {3'b000, err_a}, 4'd0);
      tick();
      rdy_a = 1'b0;
      mid();
      chk("t1_idle_gnt", gnt_a, 4'b0000);
      chk("t1_idle_mv",  {3'b000, mv_a}, 4'd0);
      chk("t1_idle_sel", {2'b00, sel_a}, 4'd2);

      // Granted requester drops req while req[0] rises; grant must hold.
      req_a = 4'b0100;
      tick();
      req_a = 4'b0001;
      mid();
      chk("t5_gnt0", gnt_a, 4'b0100);
      tick(); mid();
      chk("t5_gnt1", gnt_a, 4'b0100);
      chk("t5_sel1", {2'b00, sel_a}, 4'd2);
      tick();
      rdy_a = 1'b1;
      mid();
      chk("t5_ack", ack_a, 4'b0100);
      tick();
      rdy_a = 1'b0;
      mid();
      chk("t5_next_gnt", gnt_a, 4'b0001);
      chk("t5_next_sel", {2'b00, sel_a}, 4'd0);
      chk("t5_next_mv",  {3'b000, mv_a}, 4'd1);

      // Watchdog: requester 0 stalls; err on the 4th busy cycle.
      tick(); mid();
      chk("wd_c2_err", {3'b000, err_a}, 4'd0);
      tick(); mid();
      chk("wd_c3_err", {3'b000, err_a}, 4'd0);
      tick();
      req_a = 4'b0000;
      mid();
      chk("wd_c4_err", {3'b000, err_a}, 4'd1);
      chk("wd_c4_ack", ack_a, 4'b0000);
      chk("wd_c4_sel", {2'b00, sel_a}, 4'd0);
      chk("wd_c4_mv",  {3'b000, mv_a}, 4'd1);
      tick(); mid();
      chk("wd_after_mv",  {3'b000, mv_a}, 4'd0);
      chk("wd_after_err", {3'b000, err_a}, 4'd0);

      // Watchdog boundary: ready on the 4th cycle wins.
      req_a = 4'b0001;
      tick(); tick(); tick(); tick();
      rdy_a = 1'b1; req_a = 4'b0000;
      mid();
      chk("wdb_ack", ack_a, 4'b0001);
      chk("wdb_err", {3'b000, err_a}, 4'd0);

      // mem_ready while idle is ignored.
      tick(); mid();
      chk("idle_rdy_ack", ack_a, 4'b0000);
      chk("idle_rdy_mv",  {3'b000, mv_a}, 4'd0);
      tick(); mid();
      chk("idle_rdy_mv2", {3'b000, mv_a}, 4'd0);
      rdy_a = 1'b0;

      // Async reset while busy with requester 3.
      req_a = 4'b1000;
      tick(); mid();
      chk("rs_sel3", {2'b00, sel_a}, 4'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_gnt", gnt_a, 4'b0000);
      chk("rs_mv",  {3'b000, mv_a}, 4'd0);
      chk("rs_sel", {2'b00, sel_a}, 4'd0);
      chk("rs_err", {3'b000, err_a}, 4'd0);
      req_a = 4'b1001;
      tick();
      rst_n = 1'b1;
      tick(); mid();
      chk("rs_regrant_sel", {2'b00, sel_a}, 4'd0);
      chk("rs_regrant_gnt", gnt_a, 4'b0001);
      req_a = 4'b0000; rdy_a = 1'b1;
      tick();
      rdy_a = 1'b0;

      // Fixed priority on dut_b.
      req_b = 4'b1010; rdy_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 2) req_b = 4'b1000;
         mid();
         chk($sformatf("fp_sel%0d", k), {2'b00, sel_b}, 4'd1);
         chk($sformatf("fp_ack%0d", k), ack_b, 4'b0010);
      end
      tick();
      rdy_b = 1'b0;
      mid();
      chk("fp_sel3", {2'b00, sel_b}, 4'd3);
      chk("fp_gnt3", gnt_b, 4'b1000);
      chk("fp_ack3", ack_b, 4'b0000);
      repeat (20) tick();
      mid();
      chk("fp_nowd_mv",  {3'b000, mv_b}, 4'd1);
      chk("fp_nowd_err", {3'b000, err_b}, 4'd0);
      chk("fp_nowd_gnt", gnt_b, 4'b1000);
      req_b = 4'b0000; rdy_b = 1'b1;
      #1;
      chk("fp_final_ack", ack_b, 4'b1000);
      tick();
      rdy_b = 1'b0;
      mid();
      chk("fp_final_mv", {3'b000, mv_b}, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
